sec_core_sched: RTL and testbench
=================================

// Module: sec_core_sched
// PURPOSE
// - Time-shares one 32-bit single-error-correcting core (c499 datapath: 32 data, 8 check, 1 enable, 2 key bits) among NREQ requesters.
// - Round-robin arbitration; one operand per transaction is registered onto the core and its corrected word is returned after CORE_LAT cycles.
// - Owns the 2-bit core key register. No transaction is granted until the key is loaded.
// PARAMETERS
// - NREQ      2  number of requesters (2..8)
// - CORE_LAT  1  cycles from core operands registered to core_dout sampled (1..15)
// - IDW       1  resp_id width = max(1,$clog2(NREQ))
// PORTS
// - clk        in   1         rising-edge clock
// - rst_n      in   1         asynchronous active-low reset
// - key_load   in   1         load key_in into key register
// - key_in     in   2         key value
// - key_ready  out  1         key_load accepted this cycle (high only in IDLE)
// - key_valid  out  1         key register has been loaded since reset
// - req_valid  in   NREQ      per-requester request valid
// - req_ready  out  NREQ      one-hot grant/accept strobe
// - req_data   in   NREQ*32   data words, requester i at [32i+:32]
// - req_chk    in   NREQ*8    check bytes, requester i at [8i+:8]
// - req_en     in   NREQ      correction enable per requester (core N137)
// - core_din   out  32        to core N1..N125, bit0 = N1
// - core_chk   out  8         to core N129..N136
// - core_en    out  1         to core N137
// - core_key   out  2         to core s_1,s_0
// - core_dout  in   32        from core N724..N755
// - resp_valid out  1         response valid
// - resp_ready in   1         response accepted
// - resp_id    out  IDW       index of originating requester
// - resp_data  out  32        corrected word
// - resp_fix   out  1         corrected word differs from submitted data
// - busy       out  1         FSM not in IDLE
// BEHAVIOUR
// - Reset values: state IDLE; all outputs 0, except key_ready = 1.
//   Key register, core_din/chk/en, resp_* and rr pointer are all cleared (rr = 0).
// - Key: key_ready = (state == IDLE).
//   - key_load & key_ready: key register <= key_in, key_valid <= 1.
//   - key_load in IDLE has priority over grants; no grant is issued that cycle.
//   - key_load outside IDLE is ignored; the caller must hold it until key_ready.
//   - core_key is the key register output. It never changes during a transaction.
// - FSM:
//   - IDLE: if key_valid and any req_valid, grant winner w.
//     - req_ready[w] = 1 for exactly that cycle (combinational on req_valid, state, rr).
//     - Latch req_data[w], req_chk[w], req_en[w] into core_* regs.
//     - Save w and the submitted data. Load cnt <= CORE_LAT. Go to WAIT.
//   - WAIT: cnt decrements each cycle. On cnt == 1:
//     - Sample core_dout into resp_data.
//     - resp_fix = |(core_dout ^ saved data). resp_id = w.
//     - resp_valid <= 1. Go to RESP.
//   - RESP: hold all resp_* stable while resp_valid & !resp_ready.
//     - On resp_ready: resp_valid <= 0, rr <= (w+1) mod NREQ, go to IDLE.
// - Arbitration: first requester with req_valid, searching from rr upward with wrap.
//   rr advances only on response completion.
// - Throughput: one transaction in flight. Minimum issue-to-issue spacing is CORE_LAT+2 cycles when resp_ready is tied high.
// - Latency: grant edge to resp_valid high = CORE_LAT+1 cycles.
// - core_* registers hold their last value in IDLE; they are not cleared between transactions.
// - req_valid dropping while not granted: request is discarded, no error.
// - rst_n low mid-transaction:
//   - Immediate return to IDLE, resp_valid 0, key_valid 0.
//   - The in-flight transaction is lost.
// - NREQ == 1: arbitration is degenerate, resp_id is always 0.
// TESTING
// - Reset, then req_valid=01 without key -> req_ready stays 0 for 20 cycles; key_load=1,key_in=2'b01 -> key_valid=1 next cycle, grant follows.
// - CORE_LAT=1, req0 data=32'h0000_0000 with valid chk, en=1 -> resp_data=0, resp_fix=0, resp_id=0, 2 cycles after grant.
// - req0 data=32'h0000_0001 (single-bit error on clean zero codeword) en=1 -> resp_data=0, resp_fix=1; same with en=0 -> resp_data=1, resp_fix=0.
// - req_valid=11 held continuously, resp_ready=1 -> grants alternate 0,1,0,1, each spaced CORE_LAT+2 cycles.
// - resp_ready held 0 for 5 cycles -> resp_valid/id/data stable; no new grant, key_ready=0 until accepted.
// - rst_n pulsed low during WAIT -> resp_valid stays 0, busy=0, key_valid=0; no response emitted for the lost transaction.

Source files
------------

// File: rtl/sec_core_sched.sv
// Round-robin scheduler time-sharing one 32-bit SEC correction core among
// NREQ requesters. Owns the core key register; one transaction in flight.
module sec_core_sched #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // key register load
  input  logic                 key_load,
  input  logic [1:0]           key_in,
  output logic                 key_ready,
  output logic                 key_valid,
  // requesters
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [NREQ*8-1:0]    req_chk,
  input  logic [NREQ-1:0]      req_en,
  // shared correction core
  output logic [31:0]          core_din,
  output logic [7:0]           core_chk,
  output logic                 core_en,
  output logic [1:0]           core_key,
  input  logic [31:0]          core_dout,
  // response
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  output logic                 resp_fix,
  output logic                 busy
);

  localparam int unsigned DW   = 32;
  localparam int unsigned CHKW = 8;
  localparam int unsigned KEYW = 2;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic [KEYW-1:0]     key_q;
  logic                key_valid_q;
  logic [IDW-1:0]      rr_q;
  logic [IDW-1:0]      id_q;
  logic [DW-1:0]       sdata_q;
  logic [CNTW-1:0]     cnt_q;
  logic [DW-1:0]       core_din_q;
  logic [CHKW-1:0]     core_chk_q;
  logic                core_en_q;
  logic                resp_valid_q;
  logic [IDW-1:0]      resp_id_q;
  logic [DW-1:0]       resp_data_q;
  logic                resp_fix_q;

  logic [IDW-1:0]      win_hi_c;
  logic [IDW-1:0]      win_lo_c;
  logic                hit_hi_c;
  logic                hit_lo_c;
  logic [IDW-1:0]      win_c;
  logic                hit_c;
  logic                idle_c;
  logic                grant_c;
  logic [DW-1:0]       sel_data_c;
  logic [CHKW-1:0]     sel_chk_c;
  logic                sel_en_c;
  logic [IDW-1:0]      rr_next_c;

  // Round-robin search: lowest valid index at/above rr, else lowest overall.
  always_comb begin
    win_hi_c = '0;
    win_lo_c = '0;
    hit_hi_c = 1'b0;
    hit_lo_c = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        hit_lo_c = 1'b1;
        win_lo_c = IDW'(i);
        if (IDW'(i) >= rr_q) begin
          hit_hi_c = 1'b1;
          win_hi_c = IDW'(i);
        end
      end
    end
    win_c = hit_hi_c ? win_hi_c : win_lo_c;
    hit_c = hit_hi_c | hit_lo_c;
  end

  // Operand mux selecting the winning requester's payload.
  always_comb begin
    sel_data_c = '0;
    sel_chk_c  = '0;
    sel_en_c   = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_c == IDW'(i)) begin
        sel_data_c = req_data[i*DW +: DW];
        sel_chk_c  = req_chk[i*CHKW +: CHKW];
        sel_en_c   = req_en[i];
      end
    end
  end

  // Key load has priority over a grant in IDLE; no grant until key is valid.
  assign idle_c    = (state_q == ST_IDLE);
  assign grant_c   = idle_c && key_valid_q && !key_load && hit_c;
  assign req_ready = grant_c ? (NREQ'(1) << win_c) : '0;

  // Pointer moves past the requester whose response just completed.
  assign rr_next_c = (id_q == IDW'(NREQ - 1)) ? '0 : (id_q + IDW'(1));

  // Scheduler FSM with its datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      rr_q         <= '0;
      id_q         <= '0;
      sdata_q      <= '0;
      cnt_q        <= '0;
      core_din_q   <= '0;
      core_chk_q   <= '0;
      core_en_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_fix_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_load) begin
            key_q       <= key_in;
            key_valid_q <= 1'b1;
          end else if (grant_c) begin
            core_din_q <= sel_data_c;
            core_chk_q <= sel_chk_c;
            core_en_q  <= sel_en_c;
            sdata_q    <= sel_data_c;
            id_q       <= win_c;
            cnt_q      <= CNTW'(CORE_LAT);
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            resp_data_q  <= core_dout;
            resp_fix_q   <= |(core_dout ^ sdata_q);
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_q         <= rr_next_c;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_ready  = idle_c;
  assign busy       = !idle_c;
  assign key_valid  = key_valid_q;
  assign core_key   = key_q;
  assign core_din   = core_din_q;
  assign core_chk   = core_chk_q;
  assign core_en    = core_en_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_fix   = resp_fix_q;

endmodule

// File: tb/tb_sec_core_sched.sv
// Bench for sec_core_sched: behavioural SEC core stub, transaction-level
// reference model checked every cycle, directed scenarios then random traffic.
module tb_sec_core_sched;

  localparam int unsigned NREQ = 2;
  localparam int unsigned LAT  = 1;
  localparam int unsigned IDW  = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                key_load;
  logic [1:0]          key_in;
  logic                key_ready;
  logic                key_valid;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ*8-1:0]   req_chk;
  logic [NREQ-1:0]     req_en;
  logic [31:0]         core_din;
  logic [7:0]          core_chk;
  logic                core_en;
  logic [1:0]          core_key;
  logic [31:0]         core_dout;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [31:0]         resp_data;
  logic                resp_fix;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sec_core_sched #(.NREQ(NREQ), .CORE_LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_load(key_load), .key_in(key_in), .key_ready(key_ready), .key_valid(key_valid),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_chk(req_chk), .req_en(req_en),
    .core_din(core_din), .core_chk(core_chk), .core_en(core_en),
    .core_key(core_key), .core_dout(core_dout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_fix(resp_fix), .busy(busy)
  );

  // SEC code: each data bit has a distinct check column of weight >= 2.
  function automatic logic [7:0] col(input int i);
    return 8'((i << 3) | 3);
  endfunction

  function automatic logic [7:0] gen_chk(input logic [31:0] d);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 32; i++) if (d[i]) c = c ^ col(i);
    return c;
  endfunction

  function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c,
                                          input logic en);
    logic [7:0] s;
    if (!en) return d;
    s = gen_chk(d) ^ c;
    for (int i = 0; i < 32; i++) if (s == col(i)) return d ^ (32'd1 << i);
    return d;
  endfunction

  // Core stub: operands are held stable for the whole wait window.
  assign core_dout = correct(core_din, core_chk, core_en);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  int          cyc = 0;
  bit          busy_m = 0;
  bit          kv_m = 0;
  logic [1:0]  key_m = 2'b00;
  int          rr_m = 0;
  int          t_grant = 0;
  int          id_m = 0;
  logic [31:0] exp_data = 32'h0;
  logic        exp_fix = 1'b0;
  logic [31:0] cdin_m = 32'h0;
  logic [7:0]  cchk_m = 8'h0;
  logic        cen_m = 1'b0;
  int          gcyc[$];
  int          gid[$];

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx = (rr + k) % int'(NREQ);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: compare all outputs against the model, then advance it.
  task automatic step();
    int              w;
    bit              grant;
    bit              rv;
    logic [NREQ-1:0] exp_rdy;
    #1;
    w       = pick(req_valid, rr_m);
    grant   = !busy_m && kv_m && !key_load && (w >= 0);
    exp_rdy = '0;
    if (grant) exp_rdy[w] = 1'b1;
    rv = busy_m && (cyc >= t_grant + int'(LAT) + 1);
    check("req_ready",  32'(req_ready),  32'(exp_rdy));
    check("key_ready",  32'(key_ready),  32'(!busy_m));
    check("busy",       32'(busy),       32'(busy_m));
    check("key_valid",  32'(key_valid),  32'(kv_m));
    check("core_key",   32'(core_key),   32'(key_m));
    check("core_din",   core_din,        cdin_m);
    check("core_chk",   32'(core_chk),   32'(cchk_m));
    check("core_en",    32'(core_en),    32'(cen_m));
    check("resp_valid", 32'(resp_valid), 32'(rv));
    if (rv) begin
      check("resp_id",   32'(resp_id),  32'(id_m));
      check("resp_data", resp_data,     exp_data);
      check("resp_fix",  32'(resp_fix), 32'(exp_fix));
    end
    if (!busy_m && key_load) begin
      key_m = key_in;
      kv_m  = 1'b1;
    end else if (grant) begin
      busy_m   = 1'b1;
      t_grant  = cyc;
      id_m     = w;
      cdin_m   = req_data[32*w +: 32];
      cchk_m   = req_chk[8*w +: 8];
      cen_m    = req_en[w];
      exp_data = correct(cdin_m, cchk_m, cen_m);
      exp_fix  = (exp_data != cdin_m);
      gcyc.push_back(cyc);
      gid.push_back(w);
    end else if (rv && resp_ready) begin
      busy_m = 1'b0;
      rr_m   = (id_m + 1) % int'(NREQ);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset applied mid-cycle; everything must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    busy_m = 0; kv_m = 0; key_m = 2'b00; rr_m = 0;
    cdin_m = '0; cchk_m = '0; cen_m = 1'b0;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_key_valid",  32'(key_valid),  32'd0);
    check("rst_key_ready",  32'(key_ready),  32'd1);
    check("rst_core_key",   32'(core_key),   32'd0);
    check("rst_core_din",   core_din,        32'd0);
    check("rst_resp_data",  resp_data,       32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  // Single transaction from one requester; explicit result check at LAT+1.
  task automatic single(input int idx, input logic [31:0] d, input logic [7:0] c,
                        input logic en, input logic [31:0] xd, input logic xf,
                        input string tag);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_data[32*idx +: 32] = d;
    req_chk[8*idx +: 8]    = c;
    req_en[idx]            = en;
    step();
    req_valid = '0;
    repeat (LAT) step();
    #1;
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_data"},  resp_data,       xd);
    check({tag, "_fix"},   32'(resp_fix),   32'(xf));
    check({tag, "_id"},    32'(resp_id),    32'(idx));
    step();
  endtask

  initial begin
    int rr0;
    rst_n = 1'b0; key_load = 1'b0; key_in = 2'b00;
    req_valid = '0; req_data = '0; req_chk = '0; req_en = '0; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // No grant without a key; key load then grant on the following cycle.
    req_valid = 2'b01;
    req_data[31:0] = 32'h0; req_chk[7:0] = gen_chk(32'h0); req_en[0] = 1'b1;
    repeat (20) step();
    key_load = 1'b1; key_in = 2'b01;
    step();
    key_load = 1'b0;
    #1;
    check("key_valid_after_load", 32'(key_valid), 32'd1);
    check("grant_after_key",      32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    repeat (LAT) step();
    #1;
    check("zero_word_data", resp_data,       32'd0);
    check("zero_word_fix",  32'(resp_fix),   32'd0);
    check("zero_word_id",   32'(resp_id),    32'd0);
    step();

    // Single-bit error on the clean zero codeword, corrected and not.
    single(0, 32'h0000_0001, 8'h00, 1'b1, 32'h0000_0000, 1'b1, "err_en1");
    single(0, 32'h0000_0001, 8'h00, 1'b0, 32'h0000_0001, 1'b0, "err_en0");
    single(1, 32'h8000_0000, 8'h00, 1'b1, 32'h0000_0000, 1'b1, "err_hi");

    // Both requesting continuously: alternating grants at LAT+2 spacing.
    gcyc.delete(); gid.delete();
    rr0 = rr_m;
    req_valid = 2'b11;
    repeat (4 * (LAT + 2)) step();
    req_valid = '0;
    check("rr_grant_count", 32'(gcyc.size()), 32'd4);
    for (int k = 0; k < gid.size(); k++) begin
      check("rr_grant_id", 32'(gid[k]), 32'((rr0 + k) % int'(NREQ)));
      if (k > 0) check("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'(LAT + 2));
    end
    repeat (3) step();

    // Response back-pressure with a pending request and an ignored key load.
    resp_ready = 1'b0;
    req_valid = 2'b01;
    req_data[31:0] = 32'h1234_5678; req_chk[7:0] = gen_chk(32'h1234_5678) ^ col(5);
    req_en[0] = 1'b1;
    step();
    req_valid = 2'b11;
    repeat (LAT) step();
    key_load = 1'b1; key_in = 2'b10;
    repeat (5) step();
    #1;
    check("stall_resp_data", resp_data, 32'h1234_5678 ^ 32'h20);
    check("stall_core_key",  32'(core_key), 32'd1);
    key_load = 1'b0; resp_ready = 1'b1;
    step();
    req_valid = '0;
    repeat (4) step();

    // Reset while waiting for the core: transaction and key are lost.
    req_valid = 2'b01;
    step();
    req_valid = '0;
    do_reset();
    req_valid = 2'b11;
    repeat (6) step();
    check("post_rst_busy", 32'(busy), 32'd0);
    key_load = 1'b1; key_in = 2'b11;
    step();
    key_load = 1'b0;

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        logic [31:0] d;
        logic [7:0]  c;
        int          mode;
        d = $urandom;
        c = gen_chk(d);
        mode = int'($urandom_range(0, 3));
        if (mode == 1) d = d ^ (32'd1 << $urandom_range(0, 31));
        else if (mode == 2) c = 8'($urandom);
        req_data[32*i +: 32] = d;
        req_chk[8*i +: 8]    = c;
        req_en[i]            = 1'($urandom_range(0, 1));
      end
      req_valid  = NREQ'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      key_load   = ($urandom_range(0, 15) == 0);
      key_in     = 2'($urandom);
      if (n == 300) begin
        do_reset();
        key_load = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
